// File: rtl/fetch_stage_if.sv
// Signal bundle for fetch_stage: imem request/response, execute redirects, decode handoff.
interface fetch_stage_if;
    // valid/ready: a transfer happens on a posedge where valid and ready are both high; valid
    // never waits on ready. imem responses carry no ready and are always accepted.
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               branch_taken, branch_target, jump_taken, jump_target, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               branch_taken, branch_target, jump_taken, jump_target, if_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC owner, in-order imem reads, {pc, instr} buffer toward decode.
// Define FETCH_PERF_CNT_EN to add the fetch/redirect/discard performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_redirect_cnt,
    output logic [31:0]   perf_discard_cnt
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    logic [31:0]   pc_q;
    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;
    logic [31:0]   addr_q [MAX_OUTSTANDING];
    logic [AW-1:0] aq_rd;
    logic [AW-1:0] aq_wr;

    logic          redirect;
    logic [31:0]   target;
    logic [SW-1:0] credit;
    logic          req_fire;
    logic          push;
    logic          pop;

    function automatic logic [AW-1:0] aq_next(input logic [AW-1:0] p);
        return (p == AW'(MAX_OUTSTANDING - 1)) ? '0 : p + AW'(1);
    endfunction

    assign redirect = bus.branch_taken | bus.jump_taken;
    assign target   = (bus.jump_taken ? bus.jump_target : bus.branch_target) & 32'hFFFF_FFFC;

    // Credit counts stale in-flight words too, so every returning word always has a slot.
    assign credit   = SW'(outstanding) + SW'(count);
    assign bus.imem_req_valid = !rst && !redirect
                              && (outstanding < OW'(MAX_OUTSTANDING))
                              && (credit < SW'(FIFO_DEPTH));
    assign bus.imem_req_addr  = pc_q;
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

    assign push = bus.imem_rsp_valid && !redirect && (discard == '0);
    assign pop  = bus.if_valid && bus.if_ready && !redirect;

    assign bus.if_valid = (count != '0);
    assign bus.if_pc    = bus.if_valid ? fifo_pc[rd_ptr]    : 32'h0;
    assign bus.if_instr = bus.if_valid ? fifo_instr[rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            aq_rd       <= '0;
            aq_wr       <= '0;
        end else begin
            if (req_fire && !bus.imem_rsp_valid) begin
                outstanding <= outstanding + OW'(1);
            end else if (!req_fire && bus.imem_rsp_valid) begin
                outstanding <= outstanding - OW'(1);
            end

            if (redirect) begin
                // Everything issued so far is stale; the issued-address queue restarts empty.
                pc_q    <= target;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                aq_rd   <= '0;
                aq_wr   <= '0;
                discard <= outstanding - OW'(bus.imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    pc_q          <= pc_q + 32'd4;
                    addr_q[aq_wr] <= pc_q;
                    aq_wr         <= aq_next(aq_wr);
                end
                if (bus.imem_rsp_valid && (discard != '0)) begin
                    discard <= discard - OW'(1);
                end
                if (push) begin
                    fifo_pc[wr_ptr]    <= addr_q[aq_rd];
                    fifo_instr[wr_ptr] <= bus.imem_rsp_data;
                    wr_ptr             <= wr_ptr + PW'(1);
                    aq_rd              <= aq_next(aq_rd);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt    <= 32'h0;
            perf_redirect_cnt <= 32'h0;
            perf_discard_cnt  <= 32'h0;
        end else begin
            if (push) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
            // A response landing in a redirect cycle is stale and counts as dropped.
            if (bus.imem_rsp_valid && !push) begin
                perf_discard_cnt <= perf_discard_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: bench-side imem, decode sink and redirect source, with a
// program-order scoreboard of expected {pc, instr} pairs.
`timescale 1ns/1ps
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC        = 32'h0000_0000;
    localparam int          FIFO_DEPTH      = 4;
    localparam int          MAX_OUTSTANDING = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_stage_if bus();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;
    logic [31:0] perf_discard_cnt;
`endif

    fetch_stage #(
        .RESET_PC        (RESET_PC),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt),
        .perf_discard_cnt  (perf_discard_cnt)
`endif
    );

    logic [63:0] exp_q[$];
    logic [31:0] mem_pend[$];
    logic [31:0] model_pc = RESET_PC;
    logic        rst_prev = 1'b0;
    int n_cmp = 0;
    int n_fail = 0;
    int ready_pct = 100;
    int rsp_pct   = 100;
    int dec_pct   = 100;
    int redir_pct = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] rand_target();
        case ($urandom_range(2))
            0:       return $urandom;
            1:       return 32'hFFFF_FFE0 | ($urandom & 32'h1F);
            default: return $urandom & 32'h0000_0FFF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
        if (mem_pend.size() > 0 && $urandom_range(99) < rsp_pct) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mem_pend.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        bus.imem_req_ready = ($urandom_range(99) < ready_pct);
        bus.if_ready       = ($urandom_range(99) < dec_pct);
        bus.branch_taken   = ($urandom_range(99) < redir_pct);
        bus.jump_taken     = ($urandom_range(99) < redir_pct);
        bus.branch_target  = rand_target();
        bus.jump_target    = rand_target();
    endtask

    task automatic redirect(input logic b, input logic [31:0] bt,
                            input logic j, input logic [31:0] jt);
        cycle();
        bus.branch_taken  = b;
        bus.branch_target = bt;
        bus.jump_taken    = j;
        bus.jump_target   = jt;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_pend.delete();
        bus.imem_rsp_valid = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.jump_taken     = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Bench memory: records every accepted request; answers in order from the driver.
    always @(negedge clk) begin
        if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
            mem_pend.push_back(bus.imem_req_addr);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        logic [31:0] t;
        if (rst) begin
            if (rst_prev) begin
                check("rst_if_valid",  {31'h0, bus.if_valid}, 32'h0);
                check("rst_if_pc",     bus.if_pc, 32'h0);
                check("rst_if_instr",  bus.if_instr, 32'h0);
                check("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
                check("rst_req_addr",  bus.imem_req_addr, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
                check("rst_perf_fetch",    perf_fetch_cnt, 32'h0);
                check("rst_perf_redirect", perf_redirect_cnt, 32'h0);
                check("rst_perf_discard",  perf_discard_cnt, 32'h0);
`endif
            end
            exp_q.delete();
            model_pc = RESET_PC;
        end else if (bus.branch_taken || bus.jump_taken) begin
            // Program order restarts at the target; everything issued earlier is gone.
            check("redirect_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
            t = bus.jump_taken ? bus.jump_target : bus.branch_target;
            model_pc = {t[31:2], 2'b00};
            exp_q.delete();
        end else begin
            if (bus.if_valid && bus.if_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got pc %h, expected no entry", bus.if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", bus.if_pc, e[63:32]);
                    check("if_instr", bus.if_instr, e[31:0]);
                end
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                check("req_addr", bus.imem_req_addr, model_pc);
                exp_q.push_back({model_pc, mem_word(model_pc)});
                model_pc = model_pc + 32'd4;
            end
        end
        rst_prev = rst;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.branch_taken   = 1'b0;
        bus.branch_target  = 32'h0;
        bus.jump_taken     = 1'b0;
        bus.jump_target    = 32'h0;
        bus.if_ready       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;

        // First request right after reset; response one cycle later; if_valid the cycle after.
        @(negedge clk);
        check("first_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        check("first_if_valid0", {31'h0, bus.if_valid}, 32'h0);
        cycle();
        @(negedge clk);
        check("first_if_valid1", {31'h0, bus.if_valid}, 32'h0);
        cycle();
        @(negedge clk);
        check("first_if_valid2", {31'h0, bus.if_valid}, 32'h1);
        check("first_if_pc", bus.if_pc, RESET_PC);
        repeat (10) cycle();

        // Decode stall: buffer fills, issue stops.
        dec_pct = 0;
        repeat (10) cycle();
        @(negedge clk);
        check("stall_if_valid", {31'h0, bus.if_valid}, 32'h1);
        check("stall_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);

        // Branch with requests in flight.
        dec_pct = 100;
        rsp_pct = 0;
        repeat (6) cycle();
        rsp_pct = 100;
        redirect(1'b1, 32'h0000_0100, 1'b0, 32'h0);
        cycle();
        @(negedge clk);
        check("branch_addr", bus.imem_req_addr, 32'h0000_0100);
        check("branch_if_valid", {31'h0, bus.if_valid}, 32'h0);
        repeat (8) cycle();

        // Jump wins over a simultaneous branch.
        redirect(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300);
        cycle();
        @(negedge clk);
        check("jump_wins_addr", bus.imem_req_addr, 32'h0000_0300);
        repeat (6) cycle();

        // PC wrap at the top of the address space.
        redirect(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE);
        cycle();
        @(negedge clk);
        check("wrap_target_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 10; i++) begin
            if (bus.imem_req_addr != 32'hFFFF_FFFC) break;
            cycle();
            @(negedge clk);
        end
        check("wrap_addr", bus.imem_req_addr, 32'h0000_0000);
        repeat (8) cycle();

        // Reset with requests in flight and entries buffered.
        dec_pct = 0;
        repeat (3) cycle();
        rsp_pct = 0;
        repeat (2) cycle();
        do_reset(2);
        dec_pct = 100;
        rsp_pct = 100;
        @(negedge clk);
        check("post_rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
        check("post_rst_req_addr", bus.imem_req_addr, RESET_PC);
        repeat (5) cycle();

        // Randomized traffic.
        for (int blk = 0; blk < 30; blk++) begin
            ready_pct = $urandom_range(100, 30);
            rsp_pct   = $urandom_range(100, 20);
            dec_pct   = $urandom_range(100, 20);
            redir_pct = $urandom_range(5);
            repeat (100) cycle();
        end

        // Drain: no new issue; every expected entry must reach decode.
        ready_pct = 0;
        rsp_pct   = 100;
        dec_pct   = 100;
        redir_pct = 0;
        repeat (20) cycle();
        @(negedge clk);
        check("drain_exp_left", 32'(exp_q.size()), 32'h0);
        check("drain_if_valid", {31'h0, bus.if_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
